stall_pipe_n: RTL and testbench

- Parametrised successor of the two-lane stall pipeline.
- Computes a three-operand result (a+b+c or a+b-c) on two redundant lanes that associate the operands differently. Lane A forms (a+b)±c; lane B forms (a±c)+b.
- Adds configurable width and depth, per-stage valid tracking, output ready/valid backpressure, flush, an add/sub mode and a sticky lane-mismatch flag.
- Used as a formal/equivalence benchmark block and as a checked arithmetic pipe in datapaths.

---
 rtl/stall_pipe_pkg.sv | 21 ++
 rtl/stall_pipe_lane.sv | 72 +++++++
 rtl/stall_pipe_n.sv | 134 +++++++++++++
 tb/tb_stall_pipe_n.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_pipe_pkg.sv
// Shared types, legal depth range and the conditional-negation helper
// used by both arithmetic lanes of stall_pipe_n.
package stall_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  // Widest operand the helper handles; callers truncate to their own width,
  // which is exact because two's-complement negation is modular.
  localparam int NEG_W = 64;

  function automatic logic [NEG_W-1:0] neg_if(input op_e op, input logic [NEG_W-1:0] x);
    return (op == OP_SUB) ? (~x + NEG_W'(1)) : x;
  endfunction

endpackage

// File: rtl/stall_pipe_lane.sv
// One arithmetic lane of stall_pipe_n: stage-0 operand pairing, stage-1 sum
// and the delay line. ASSOC=0 forms (a+b)+/-c, ASSOC=1 forms (a+/-c)+b.
// STALL_PIPE_N_ASSERT_EN adds a per-stage sum port used by the top's checks.
module stall_pipe_lane
  import stall_pipe_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int ASSOC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv_i,
  input  op_e          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_last_o
`ifdef STALL_PIPE_N_ASSERT_EN
  ,
  output logic [DEPTH-1:0][W-1:0] stage_sum_o
`endif
);

  logic [W-1:0] c_sel;
  logic [W-1:0] x_d, y_d;
  logic [W-1:0] x_q, y_q;
  logic [W-1:0] s_q [1:DEPTH-1];

  assign c_sel = W'(neg_if(op_i, NEG_W'(c_i)));

  generate
    if (ASSOC == 0) begin : g_assoc_a
      assign x_d = a_i + b_i;
      assign y_d = c_sel;
    end else begin : g_assoc_b
      assign x_d = a_i + c_sel;
      assign y_d = b_i;
    end
  endgenerate

  // Data registers advance regardless of valid bits; only hold freezes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        s_q[i] <= '0;
      end
    end else if (adv_i) begin
      x_q    <= x_d;
      y_q    <= y_d;
      s_q[1] <= x_q + y_q;
      for (int i = 2; i < DEPTH; i++) begin
        s_q[i] <= s_q[i-1];
      end
    end
  end

  assign sum_last_o = s_q[DEPTH-1];

`ifdef STALL_PIPE_N_ASSERT_EN
  genvar gi;
  assign stage_sum_o[0] = x_q + y_q;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage_sum
      assign stage_sum_o[gi] = s_q[gi];
    end
  endgenerate
`endif

endmodule

// File: rtl/stall_pipe_n.sv
// Two-lane checked three-operand pipe with valid tracking, backpressure,
// flush and sticky lane-mismatch flag. STALL_PIPE_N_ASSERT_EN enables checks.
module stall_pipe_n
  import stall_pipe_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         mismatch
);

  genvar gi;

  logic             hold;
  logic             advance;
  op_e              op;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             mismatch_q, mismatch_d;
  logic [W-1:0]     sum_a, sum_b;

  generate
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
      $error("stall_pipe_n: DEPTH out of range");
    end
  endgenerate

  assign op       = op_e'(mode);
  assign hold     = stall | (out_valid & ~out_ready);
  assign advance  = ~hold;
  assign in_ready = ~hold & ~flush;

`ifdef STALL_PIPE_N_ASSERT_EN
  logic [DEPTH-1:0][W-1:0] stage_a, stage_b;
`endif

  stall_pipe_lane #(.W(W), .DEPTH(DEPTH), .ASSOC(0)) u_lane_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (advance),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .sum_last_o (sum_a)
`ifdef STALL_PIPE_N_ASSERT_EN
    ,
    .stage_sum_o(stage_a)
`endif
  );

  stall_pipe_lane #(.W(W), .DEPTH(DEPTH), .ASSOC(1)) u_lane_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (advance),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .sum_last_o (sum_b)
`ifdef STALL_PIPE_N_ASSERT_EN
    ,
    .stage_sum_o(stage_b)
`endif
  );

  // Flush beats hold for the valid bits only; data still follows hold.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (advance) begin
      valid_d = {valid_q[DEPTH-2:0], in_valid & in_ready};
    end
  end

  always_comb begin
    mismatch_d = mismatch_q | (out_valid & (sum_a != sum_b));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = sum_a;
  assign mismatch  = mismatch_q;

`ifdef STALL_PIPE_N_ASSERT_EN
  logic init_q = 1'b1;

  always_ff @(posedge clk) begin
    init_q <= 1'b0;
  end

  always_comb begin
    assume (!rst_n == init_q);
  end

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_inv
      a_stage_inv: assert property (@(posedge clk) disable iff (!rst_n)
        stage_a[gi] == stage_b[gi]);
    end
  endgenerate

  a_no_mismatch: assert property (@(posedge clk) disable iff (!rst_n) !mismatch);

  a_hold_data: assert property (@(posedge clk) disable iff (!rst_n)
    hold |=> $stable(out_data));

  a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (hold && !flush) |=> $stable(out_valid));
`endif

endmodule

// File: tb/tb_stall_pipe_n.sv
// Scoreboard testbench for stall_pipe_n: expected results are queued on
// acceptance and compared (value and arrival cycle) when the pipe delivers.
module tb_stall_pipe_n;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] a, b, c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         mismatch;

  typedef struct {
    logic [W-1:0] data;
    int           acc_cyc;
    int           hold_at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   hold_cnt;
  int   n_tests;
  int   n_fail;

  stall_pipe_n #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] z);
    if (m) return x + y - z;
    return x + y + z;
  endfunction

  // One clock: sample mid-cycle, update the scoreboard, return to posedge+1.
  task automatic clock_cycle(output logic fire, output logic [W-1:0] got, output int got_cyc,
                             output logic have, output logic [W-1:0] want, output int want_cyc);
    exp_t e;
    logic take;
    @(negedge clk);
    fire     = out_valid && out_ready && !stall;
    got      = out_data;
    got_cyc  = cyc;
    have     = 1'b0;
    want     = '0;
    want_cyc = -1;
    take     = in_valid && !stall && !(out_valid && !out_ready) && !flush;
    if (stall || (out_valid && !out_ready)) hold_cnt++;
    if (fire && exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      have     = 1'b1;
      want     = e.data;
      want_cyc = e.acc_cyc + DEPTH + (hold_cnt - e.hold_at);
    end
    if (flush) exp_q.delete();
    if (take) begin
      e.data    = model(mode, a, b, c);
      e.acc_cyc = cyc;
      e.hold_at = hold_cnt;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0000", out_data); end
    n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch: got %b, required 0", mismatch); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_basic();
    logic f, h, seen;
    logic [W-1:0] g, w;
    int gc, wc;
    seen = 1'b0;
    for (int i = 0; i < 4 * DEPTH && !seen; i++) begin
      in_valid = (i == 0);
      mode = 1'b0; a = 16'd3; b = 16'd4; c = 16'd5;
      clock_cycle(f, g, gc, h, w, wc);
      if (f) begin
        seen = 1'b1;
        n_tests++;
        if (!h || g !== w || g !== 16'd12 || gc != wc) begin
          n_fail++;
          $display("FAIL basic_out: got %h @%0d, required %h (12) @%0d entry=%b", g, gc, w, wc, h);
        end else $display("[TB] basic out %h @%0d", g, gc);
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL basic_timeout: got no out_valid, required one"); end
    n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL basic_mismatch: got %b, required 0", mismatch); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] ta [2] = '{16'h0001, 16'hFFFF};
    logic [W-1:0] tb [2] = '{16'h0001, 16'h0001};
    logic [W-1:0] tc [2] = '{16'h0003, 16'h0000};
    logic         tm [2] = '{1'b1, 1'b0};
    logic [W-1:0] req [2] = '{16'hFFFF, 16'h0000};
    logic f, h;
    logic [W-1:0] g, w;
    int gc, wc, outs;
    outs = 0;
    for (int i = 0; i < 4 * DEPTH && outs < 2; i++) begin
      in_valid = (i < 2);
      if (i < 2) begin a = ta[i]; b = tb[i]; c = tc[i]; mode = tm[i]; end
      clock_cycle(f, g, gc, h, w, wc);
      if (f) begin
        n_tests++;
        if (!h || g !== w || g !== req[outs] || gc != wc) begin
          n_fail++;
          $display("FAIL wrap_out: got %h @%0d, required %h @%0d entry=%b", g, gc, req[outs], wc, h);
        end else $display("[TB] wrap out %h @%0d", g, gc);
        outs++;
      end
    end
    n_tests++; if (outs != 2) begin n_fail++; $display("FAIL wrap_count: got %0d outputs, required 2", outs); end
  endtask

  task automatic test_stall();
    logic f, h, pv;
    logic [W-1:0] g, w, pd;
    int gc, wc, sent, outs;
    sent = 0; outs = 0; mode = 1'b0;
    for (int i = 0; i < 30 && outs < 6; i++) begin
      stall    = (i >= 2 && i <= 4);
      in_valid = (sent < 6);
      a = W'($urandom); b = W'($urandom); c = W'($urandom); mode = ~mode;
      pv = out_valid; pd = out_data;
      #1;
      if (stall) begin
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
      end
      if (in_valid && !stall) sent++;
      clock_cycle(f, g, gc, h, w, wc);
      if (stall) begin
        n_tests++;
        if (out_valid !== pv || out_data !== pd) begin
          n_fail++;
          $display("FAIL stall_frozen: got %b/%h, required %b/%h", out_valid, out_data, pv, pd);
        end
      end
      if (f) begin
        n_tests++;
        if (!h || g !== w || gc != wc) begin
          n_fail++;
          $display("FAIL stall_out: got %h @%0d, required %h @%0d entry=%b", g, gc, w, wc, h);
        end else $display("[TB] stall out %h @%0d", g, gc);
        outs++;
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    n_tests++; if (outs != 6) begin n_fail++; $display("FAIL stall_count: got %0d outputs, required 6", outs); end
  endtask

  task automatic test_backpressure();
    logic f, h, seen;
    logic [W-1:0] g, w, held;
    int gc, wc, outs, first_cyc, last_cyc;
    seen = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4 * DEPTH && !seen; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); c = W'($urandom); mode = i[0];
      clock_cycle(f, g, gc, h, w, wc);
      seen = out_valid;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL bp_fill: got no out_valid, required one"); end
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom);
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
      clock_cycle(f, g, gc, h, w, wc);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        n_fail++;
        $display("FAIL bp_stable: got %b/%h, required 1/%h", out_valid, out_data, held);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    outs = 0; first_cyc = -1; last_cyc = -1;
    for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) begin
      clock_cycle(f, g, gc, h, w, wc);
      if (f) begin
        n_tests++;
        if (!h || g !== w || gc != wc) begin
          n_fail++;
          $display("FAIL bp_out: got %h @%0d, required %h @%0d entry=%b", g, gc, w, wc, h);
        end else $display("[TB] bp out %h @%0d", g, gc);
        if (first_cyc < 0) first_cyc = gc;
        last_cyc = gc;
        outs++;
      end
    end
    n_tests++;
    if (outs != DEPTH || last_cyc - first_cyc != DEPTH - 1) begin
      n_fail++;
      $display("FAIL bp_burst: got %0d outputs over %0d cycles, required %0d back-to-back", outs,
               last_cyc - first_cyc + 1, DEPTH);
    end
  endtask

  task automatic test_flush();
    logic f, h, seen;
    logic [W-1:0] g, w;
    int gc, wc, stray;
    out_ready = 1'b1; stray = 0; seen = 1'b0;
    for (int i = 0; i < 3 + DEPTH + 2; i++) begin
      flush    = (i == 3);
      in_valid = (i <= 3);
      a = W'($urandom); b = W'($urandom); c = W'($urandom); mode = i[1];
      if (flush) begin
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
      end
      clock_cycle(f, g, gc, h, w, wc);
      if (f) begin
        stray++;
        $display("[TB] flush stray out %h @%0d", g, gc);
      end
    end
    flush = 1'b0;
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL flush_drop: got %0d outputs, required 0", stray); end
    for (int i = 0; i < 4 * DEPTH && !seen; i++) begin
      in_valid = (i == 0);
      a = 16'h1234; b = 16'h0101; c = 16'h0034; mode = 1'b1;
      clock_cycle(f, g, gc, h, w, wc);
      if (f) begin
        seen = 1'b1;
        n_tests++;
        if (!h || g !== w || gc != wc) begin
          n_fail++;
          $display("FAIL flush_next: got %h @%0d, required %h @%0d entry=%b", g, gc, w, wc, h);
        end else $display("[TB] flush next out %h @%0d", g, gc);
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL flush_timeout: got no out_valid, required one"); end
  endtask

  task automatic test_reset_midstream();
    logic f, h, seen;
    logic [W-1:0] g, w;
    int gc, wc;
    out_ready = 1'b1; seen = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); c = W'($urandom); mode = i[0];
      clock_cycle(f, g, gc, h, w, wc);
      if (f) begin
        n_tests++;
        if (!h || g !== w || gc != wc) begin
          n_fail++;
          $display("FAIL rstmid_out: got %h @%0d, required %h @%0d entry=%b", g, gc, w, wc, h);
        end else $display("[TB] rstmid out %h @%0d", g, gc);
      end
    end
    stall = 1'b1;
    #2;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b, required 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h, required 0000", out_data); end
    n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL rstmid_mismatch: got %b, required 0", mismatch); end
    exp_q.delete();
    stall = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b, required 1", in_ready); end
    for (int i = 0; i < 4 * DEPTH && !seen; i++) begin
      in_valid = (i == 0);
      a = 16'd10; b = 16'd20; c = 16'd7; mode = 1'b1;
      clock_cycle(f, g, gc, h, w, wc);
      if (f) begin
        seen = 1'b1;
        n_tests++;
        if (!h || g !== w || g !== 16'd23 || gc != wc) begin
          n_fail++;
          $display("FAIL rstmid_resume: got %h @%0d, required %h (23) @%0d entry=%b", g, gc, w, wc, h);
        end else $display("[TB] rstmid resume out %h @%0d", g, gc);
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rstmid_timeout: got no out_valid, required one"); end
    n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL final_mismatch: got %b, required 0", mismatch); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; hold_cnt = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 1'b0; a = '0; b = '0; c = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
